// File: rtl/byte_serial_addsub_ctrl_if.sv
// Operand/result handshake bundle for the byte-serial adder/subtractor.
// The slave modport is the arithmetic block; the master is the issuing side.
interface byte_serial_addsub_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/byte_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract built from one 8-bit ripple adder reused once per byte,
// LSB first, with a registered carry linking the slices.
module rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [8:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[8];
endmodule

module byte_serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  byte_serial_addsub_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 8;
  localparam int IDXW   = $clog2(NSLICE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bm_q, bm_d;
  logic             mode_q, mode_d;

  logic [7:0] a_bytes  [NSLICE];
  logic [7:0] bm_bytes [NSLICE];
  logic [7:0] slice_a, slice_b, slice_s;
  logic       slice_cin, slice_cout;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_bytes
      assign a_bytes[gi]  = a_q[8*gi +: 8];
      assign bm_bytes[gi] = bm_q[8*gi +: 8];
    end
  endgenerate

  // Slice 0 takes the subtract's +1 from mode; later slices take the stored carry.
  assign slice_a   = a_bytes[idx_q];
  assign slice_b   = bm_bytes[idx_q];
  assign slice_cin = (idx_q == '0) ? mode_q : carry_q;

  rca8 u_rca8 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    bm_d    = bm_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          bm_d    = bus.b ^ {WIDTH{bus.mode}};
          mode_d  = bus.mode;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[8*i +: 8] = slice_s;
          end
        end
        carry_d = slice_cout;
        if (idx_q == IDXW'(NSLICE - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers are cleared too so ovf decodes to 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      a_q     <= '0;
      bm_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      bm_q    <= bm_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;
  assign bus.ovf       = (a_q[WIDTH-1] == bm_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
  assign bus.zero      = (sum_q == '0);
endmodule
